fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage directly downstream of the 8-bit synchronous FIFO. It pops one byte at a time when the FIFO is non-empty and shifts it out as an asynchronous 8N1 UART frame on a single line. Each byte is popped once, transmitted once and never re-read. Baud rate is set by a clock-divider parameter.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are ≥ 2. The divider counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`  in  1: single clock. Everything is sampled on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `fifo_empty`  in  1: the FIFO `empty` flag.
- `fifo_dout`  in  8: FIFO read data. It is valid on the cycle after the FIFO samples `rd_en` high.
- `tx_enable`  in  1: permits new frames to start. It never aborts a frame in flight.
- `fifo_rd_en`  out  1: FIFO pop request. It is registered and lasts exactly one cycle per byte.
- `tx`  out  1: serial line. Idle level is 1.
- `busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse marking the end of the stop bit.

## Operation
- Reset values (forced asynchronously while `reset` = 0):
  - state = IDLE
  - `tx` = 1
  - `fifo_rd_en` = 0
  - `busy` = 0
  - `tx_done` = 0
  - shift register and bit/baud counters = 0
- States are IDLE → POP → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: if `tx_enable` = 1 and `fifo_empty` = 0, the next edge sets `fifo_rd_en` = 1 and goes to POP. Otherwise the block stays in IDLE with `tx` = 1.
- POP: the next edge clears `fifo_rd_en` and goes to LOAD. The FIFO updates `fifo_dout` on this edge.
- LOAD: the next edge captures `fifo_dout` into the shift register, drives `tx` = 0 and goes to START.
- START: holds `tx` = 0 for CLKS_PER_BIT cycles.
- DATA: sends 8 bits LSB first, each held for CLKS_PER_BIT cycles. The bit counter runs 0..7.
- STOP: holds `tx` = 1 for CLKS_PER_BIT cycles. On the final cycle `tx_done` = 1 and the next state is IDLE.
- The block never asserts `fifo_rd_en` while `fifo_empty` = 1.
- It never issues a second pop before the current frame finishes. At most one byte is in flight.
- `fifo_empty` and `tx_enable` are ignored outside IDLE.
- `tx_enable` dropping mid-frame: the frame completes and no new frame starts.
- Reset mid-frame: `tx` returns to 1 immediately and the in-flight byte is discarded, not re-sent. The FIFO's own reset behaviour is outside this block.
- Baud counter: counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit. It is cleared on every state change.

## Timing
- Pop-to-start latency: `fifo_rd_en` rises one edge after IDLE sees a non-empty FIFO. `tx` falls 2 edges after that.
- Frame length, from `tx` falling to the end of the stop bit: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back bytes: the IDLE→POP→LOAD turnaround adds exactly 3 cycles of `tx` = 1 after the stop bit. The stop bit is effectively CLKS_PER_BIT+3 cycles long.
- `tx_done` is high in the same cycle as the last stop-bit cycle. `busy` falls on the following edge.
- All outputs are registered, with no combinational paths from inputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - adds a PARITY state between DATA and STOP;
  - `tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles;
  - frame is 11·CLKS_PER_BIT.
- Undefined: DATA goes straight to STOP, giving 8N1 with a 10·CLKS_PER_BIT frame. No parity logic is generated.

## Test plan
- Single byte, CLKS_PER_BIT=4, FIFO holding 0x11:
  - exactly one `fifo_rd_en` pulse;
  - `tx` sequence, 4 cycles per bit: 0, 1,0,0,0,1,0,0,0, 1;
  - one `tx_done`, then `busy` = 0 and `tx` = 1.
- FIFO written with 0x11, 0x22, 0x33, 0x44 back-to-back:
  - four frames decode to 0x11, 0x22, 0x33, 0x44 in order;
  - 4 `fifo_rd_en` pulses;
  - 3-cycle idle gap between frames;
  - no pop once `fifo_empty` = 1.
- FIFO empty for 100 cycles: `fifo_rd_en` = 0, `tx` = 1, `busy` = 0 throughout.
- `tx_enable` = 0 with data present:
  - no pop occurs;
  - deassert mid-frame: the current frame completes and no further pop follows.
- `reset` low during DATA bit 3:
  - `tx` = 1 and `busy` = 0 asynchronously;
  - after release, the next FIFO byte is transmitted.
- With `UART_TX_PARITY_EN`:
  - 0x33 gives parity bit 0; 0x07 gives parity bit 1;
  - frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Bundles the FIFO read side and the serial side of the UART transmit stage.
//   fifo_empty  : FIFO empty flag                      (environment -> tx stage)
//   fifo_dout   : FIFO read data, valid after a pop    (environment -> tx stage)
//   tx_enable   : permits new frames to start          (environment -> tx stage)
//   fifo_rd_en  : one-cycle FIFO pop request           (tx stage -> environment)
//   tx          : serial line, idle high               (tx stage -> environment)
//   busy        : high whenever the stage is not idle  (tx stage -> environment)
//   tx_done     : pulse on the last stop-bit cycle     (tx stage -> environment)
// Modports: master = the transmit stage, slave = the FIFO/line side.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       tx_enable;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    input  fifo_empty, fifo_dout, tx_enable,
    output fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_enable,
    input  fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops one byte at a time from an 8-bit synchronous FIFO and shifts it out as
// an asynchronous UART frame (start, 8 data bits LSB first, [parity], stop).
// At most one byte is in flight; a byte is popped once and sent once.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : fifo_uart_tx_if.master (FIFO read side + serial line + status)
// Build option:
//   UART_TX_PARITY_EN : when defined, an even-parity bit is sent between the
//                       last data bit and the stop bit (11-bit frame).
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            r_state;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit;
  logic [BAUD_W-1:0] r_baud;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_baud_last;
  assign w_baud_last = (r_baud == BAUD_LAST);

  // NOTE: every output is driven straight from a flop, so nothing on the
  // input side of the interface can reach an output combinationally.
  assign bus.fifo_rd_en = r_rd_en;
  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.tx_done    = r_done;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_baud   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      // NOTE: single-cycle pulses default low here and are raised only in
      // the one branch that needs them.
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.tx_enable && !bus.fifo_empty) begin
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_POP;
          end
        end

        // The FIFO samples rd_en on this edge; its data is valid in LOAD.
        S_POP: r_state <= S_LOAD;

        S_LOAD: begin
          r_shift  <= bus.fifo_dout;
`ifdef UART_TX_PARITY_EN
          r_parity <= ^bus.fifo_dout;
`endif
          r_tx     <= 1'b0;
          r_baud   <= '0;
          r_state  <= S_START;
        end

        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
            // Raised one edge early so the registered pulse lands on the
            // final stop-bit cycle.
            if (r_baud == BAUD_PRE) r_done <= 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Scoreboard bench for fifo_uart_tx at CLKS_PER_BIT = 4. A queue models the
// FIFO; every byte written into it is also pushed onto an expected-frame
// queue. An independent UART receiver decodes the serial line, checks frame
// shape, parity, tx_done placement and pop behaviour, and pops the expected
// queue for each completed frame.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = (PAR ? 11 : 10) * CPB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_uart_tx_if bus ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk)
    if (bus.fifo_rd_en && fifo_q.size() != 0) bus.fifo_dout <= fifo_q.pop_front();

  always @(negedge clk) bus.fifo_empty = (fifo_q.size() == 0);

  task automatic push_byte(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  // ---------------- Receiver / monitor ----------------
  bit         mon_active;
  int         mon_off;
  int         mon_b;
  logic [7:0] mon_data;
  int         cyc = 0;
  int         last_pop_cyc = -100;
  int         pops = 0;
  int         frames = 0;
  int         dones = 0;
  bit         prev_rd;
  int         start_cycles[$];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mon_active = 1'b0;
      prev_rd    = 1'b0;
    end else begin
      cyc++;
      if (bus.fifo_rd_en) begin
        check("rd_en_while_empty", bus.fifo_empty, 1'b0);
        check("rd_en_one_cycle", prev_rd, 1'b0);
        last_pop_cyc = cyc;
        pops++;
      end
      prev_rd = bus.fifo_rd_en;
      if (bus.tx_done) dones++;

      if (!mon_active) begin
        if (bus.tx == 1'b0) begin
          mon_active = 1'b1;
          mon_off    = 0;
          mon_data   = '0;
          check("pop_to_start", cyc - last_pop_cyc, 2);
          start_cycles.push_back(cyc);
        end
      end else begin
        mon_off++;
      end

      check("tx_done_place", bus.tx_done, mon_active && (mon_off == FRAME - 1));

      if (mon_active && (mon_off % CPB) == CPB / 2) begin
        mon_b = mon_off / CPB;
        check("busy_in_frame", bus.busy, 1'b1);
        if (mon_b == 0)                check("start_bit", bus.tx, 1'b0);
        else if (mon_b <= 8)           mon_data[mon_b-1] = bus.tx;
        else if (mon_b == 9 && PAR)    check("parity_bit", bus.tx, ^mon_data);
        else                           check("stop_bit", bus.tx, 1'b1);
      end

      if (mon_active && mon_off == FRAME - 1) begin
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("frame_data", mon_data, exp_q.pop_front());
        frames++;
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- Helpers ----------------
  task automatic wait_drain(input int limit);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || bus.busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < limit, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  initial begin
    int p0, f0, d0, n;
    reset         = 1'b0;
    bus.tx_enable = 1'b0;
    bus.fifo_dout = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_tx_done", bus.tx_done, 1'b0);
    reset = 1'b1;
    bus.tx_enable = 1'b1;

    // Empty FIFO: line stays idle.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("empty_rd_en", bus.fifo_rd_en, 1'b0);
      check("empty_tx", bus.tx, 1'b1);
      check("empty_busy", bus.busy, 1'b0);
    end

    // Single byte.
    p0 = pops; f0 = frames; d0 = dones;
    push_byte(8'h11);
    wait_drain(500);
    check("single_pops", pops - p0, 1);
    check("single_frames", frames - f0, 1);
    check("single_dones", dones - d0, 1);
    check("single_idle_tx", bus.tx, 1'b1);
    check("single_idle_busy", bus.busy, 1'b0);

    // Back-to-back burst: fixed 3-cycle turnaround between frames.
    p0 = pops;
    start_cycles.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_drain(1000);
    check("burst_pops", pops - p0, 4);
    check("burst_starts", start_cycles.size(), 4);
    for (int i = 0; i + 1 < start_cycles.size(); i++)
      check("burst_gap", start_cycles[i+1] - start_cycles[i], FRAME + 3);

    // Parity corner bytes (decoded and parity-checked by the receiver).
    push_byte(8'h33); push_byte(8'h07);
    wait_drain(1000);

    // Random bytes with random gaps.
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_drain(3000);
    check("rand_pops", pops - p0, 8);

    // tx_enable low with data present: no pop.
    bus.tx_enable = 1'b0;
    p0 = pops;
    push_byte(8'h5A); push_byte(8'hC3);
    repeat (40) @(negedge clk);
    check("disabled_pops", pops - p0, 0);
    check("disabled_busy", bus.busy, 1'b0);
    check("disabled_tx", bus.tx, 1'b1);

    // Enable, then drop mid-frame: the frame finishes, nothing further pops.
    bus.tx_enable = 1'b1;
    n = 0;
    while (!bus.busy && n < 100) begin @(negedge clk); n++; end
    check("enable_busy_rise", bus.busy, 1'b1);
    repeat (10) @(negedge clk);
    bus.tx_enable = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    check("middrop_pops", pops - p0, 1);
    check("middrop_pending", exp_q.size(), 1);
    check("middrop_busy", bus.busy, 1'b0);
    bus.tx_enable = 1'b1;
    wait_drain(1000);

    // Reset during data bit 3: in-flight byte is discarded, next one is sent.
    p0 = pops;
    push_byte(8'hA5); push_byte(8'h3C);
    n = 0;
    while (!(mon_active && mon_off == 4 * CPB + 1) && n < 500) begin @(negedge clk); n++; end
    check("reset_reach_bit3", n < 500, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("midrst_tx", bus.tx, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_rd_en", bus.fifo_rd_en, 1'b0);
    exp_q.delete(0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_drain(1000);
    check("midrst_pops", pops - p0, 2);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
